// File: rtl/aes_word_io_ctrl_pkg.sv
// Shared constants, FSM encoding and word-slot helper for the AES word I/O controller.
package aes_word_io_ctrl_pkg;

    localparam int WORD_W          = 32;
    localparam int KEY_WORDS       = 4;
    localparam int STATE_WORDS     = 4;
    localparam int BLOCK_WORDS     = KEY_WORDS + STATE_WORDS;
    localparam int DEFAULT_LATENCY = 21;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

    // Slot 0 is the most-significant word of a 128-bit vector.
    function automatic logic [6:0] wordLsb(input logic [1:0] slot);
        return {2'd3 - slot, 5'd0};
    endfunction

endpackage

// File: rtl/aes_word_unpacker.sv
// Captures the core's 128-bit ciphertext and streams it out as four 32-bit words, MSW first.
module aes_word_unpacker
    import aes_word_io_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic [127:0]      i_aesOut,
    input  logic              i_outReady,
    output logic              o_outValid,
    output logic [WORD_W-1:0] o_outData,
    output logic              o_lastWord
);

    logic [127:0]      r_capture;
    logic [1:0]        r_drainIdx;
    logic              r_outValid;
    logic [WORD_W-1:0] r_outData;
    logic              w_outXfer;

    assign w_outXfer  = r_outValid && i_outReady;
    assign o_lastWord = w_outXfer && (r_drainIdx == 2'd3);
    assign o_outValid = r_outValid;
    assign o_outData  = r_outData;

    // out_data is preloaded with the next word so it stays registered and stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_capture  <= '0;
            r_drainIdx <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (i_capture) begin
            r_capture  <= i_aesOut;
            r_drainIdx <= '0;
            r_outValid <= 1'b1;
            r_outData  <= i_aesOut[wordLsb(2'd0) +: WORD_W];
        end else if (w_outXfer) begin
            r_drainIdx <= r_drainIdx + 2'd1;
            if (r_drainIdx == 2'd3) begin
                r_outValid <= 1'b0;
            end else begin
                r_outData <= r_capture[wordLsb(r_drainIdx + 2'd1) +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/aes_word_io_ctrl.sv
// Word-serial front/back end for the AES core: loads key then plaintext, holds them
// for the core latency, then hands the ciphertext to the unpacker for draining.
module aes_word_io_ctrl
    import aes_word_io_ctrl_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [127:0]      aes_state,
    output logic [127:0]      aes_key,
    input  logic [127:0]      aes_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              busy
);

    ctrl_state_e      r_state;
    ctrl_state_e      w_nextState;
    logic [2:0]       r_wordIdx;
    logic [CNT_W-1:0] r_cnt;
    logic [127:0]     r_key;
    logic [127:0]     r_aesState;
    logic             r_busy;
    logic             w_inReady;
    logic             w_inXfer;
    logic             w_runDone;
    logic             w_lastWord;

    assign w_inXfer  = in_valid && w_inReady;
    assign w_runDone = (r_state == RUN) && (r_cnt == CNT_W'(LATENCY - 1));

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        case (r_state)
            LOAD: begin
                w_inReady = 1'b1;
                if (in_valid && (r_wordIdx == 3'(BLOCK_WORDS - 1))) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_runDone) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastWord) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The 3-bit word index wraps to 0 on its own after word 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wordIdx  <= '0;
            r_cnt      <= '0;
            r_key      <= '0;
            r_aesState <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_nextState != LOAD);
            if (w_inXfer) begin
                r_wordIdx <= r_wordIdx + 3'd1;
                if (r_wordIdx < 3'(KEY_WORDS)) begin
                    r_key[wordLsb(r_wordIdx[1:0]) +: WORD_W] <= in_data;
                end else begin
                    r_aesState[wordLsb(r_wordIdx[1:0]) +: WORD_W] <= in_data;
                end
                if (r_wordIdx == 3'(BLOCK_WORDS - 1)) begin
                    r_cnt <= '0;
                end
            end
            if (r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    aes_word_unpacker u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_runDone),
        .i_aesOut   (aes_out),
        .i_outReady (out_ready),
        .o_outValid (out_valid),
        .o_outData  (out_data),
        .o_lastWord (w_lastWord)
    );

    assign in_ready  = w_inReady;
    assign aes_key   = r_key;
    assign aes_state = r_aesState;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_word_io_ctrl.sv
// Bench for aes_word_io_ctrl: table-driven FIPS blocks, directed corner sequences and
// random blocks, all checked against a block-level reference model and a LATENCY=1 build.
module tb_aes_word_io_ctrl;

    localparam int LAT = 21;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid, inReady, outValid, outReady, busy;
    logic [31:0]  inData, outData;
    logic [127:0] aesState, aesKey, aesOut;

    logic         inValid1, inReady1, outValid1, outReady1, busy1;
    logic [31:0]  inData1, outData1;
    logic [127:0] aesState1, aesKey1, aesOut1;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    aes_word_io_ctrl #(.LATENCY(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .aes_state(aesState), .aes_key(aesKey), .aes_out(aesOut),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .busy(busy)
    );

    aes_word_io_ctrl #(.LATENCY(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
        .aes_state(aesState1), .aes_key(aesKey1), .aes_out(aesOut1),
        .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1), .busy(busy1)
    );

    // Known AES-128 answers for the two published vectors; any other block gets an
    // arbitrary stand-in mapping, since the controller only moves data around.
    function automatic logic [127:0] coreModel(input logic [127:0] key, input logic [127:0] pt);
        if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
        if (key == B_KEY && pt == B_PT) return B_CT;
        return key ^ {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [31:0] wordOf(input logic [127:0] v, input int i);
        return v[127 - 32*i -: 32];
    endfunction

    typedef enum {M_LOAD, M_RUN, M_DRAIN} mode_e;
    mode_e        mMode;
    int           mLoaded, mRun, mDrained;
    logic [127:0] mKey, mPt, mCt;
    logic         mOutValid, mBusy;
    logic [31:0]  mOutData;

    // The core output is only correct on the cycle its latency expires, so a capture
    // on any other edge picks up the complemented value.
    assign aesOut = (mMode == M_RUN && mRun == LAT - 1) ? coreModel(mKey, mPt) : ~coreModel(mKey, mPt);

    always @(posedge clk) begin
        if (rst) begin
            mMode <= M_LOAD; mLoaded <= 0; mRun <= 0; mDrained <= 0;
            mKey <= '0; mPt <= '0; mCt <= '0;
            mOutValid <= 1'b0; mOutData <= '0; mBusy <= 1'b0;
        end else begin
            case (mMode)
                M_LOAD: if (inValid) begin
                    if (mLoaded < 4) mKey[127 - 32*mLoaded -: 32] <= inData;
                    else             mPt[127 - 32*(mLoaded - 4) -: 32] <= inData;
                    if (mLoaded == 7) begin
                        mLoaded <= 0; mRun <= 0; mMode <= M_RUN; mBusy <= 1'b1;
                    end else begin
                        mLoaded <= mLoaded + 1;
                    end
                end
                M_RUN: if (mRun == LAT - 1) begin
                    mCt <= coreModel(mKey, mPt);
                    mOutData <= wordOf(coreModel(mKey, mPt), 0);
                    mOutValid <= 1'b1; mDrained <= 0; mMode <= M_DRAIN;
                end else begin
                    mRun <= mRun + 1;
                end
                M_DRAIN: if (outReady) begin
                    if (mDrained == 3) begin
                        mOutValid <= 1'b0; mBusy <= 1'b0; mDrained <= 0; mMode <= M_LOAD;
                    end else begin
                        mDrained <= mDrained + 1;
                        mOutData <= wordOf(mCt, mDrained + 1);
                    end
                end
                default: mMode <= M_LOAD;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cycInReady", inReady, mMode == M_LOAD);
            checkOutput("cycBusy", busy, mBusy);
            checkOutput("cycOutValid", outValid, mOutValid);
            if (mOutValid) checkOutput("cycOutData", outData, mOutData);
            checkOutput("cycAesKey", aesKey, mKey);
            checkOutput("cycAesState", aesState, mPt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gapMode: 0 back-to-back, 1 in_valid toggling every cycle, 2 random idle cycles.
    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt, input int gapMode);
        bit done, idle, accepted, phase;
        int guard;
        phase = 1'b0;
        for (int i = 0; i < 8; i++) begin
            done = 1'b0;
            guard = 0;
            while (!done && guard < 100) begin
                idle = (gapMode == 1) ? phase : (gapMode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
                phase = ~phase;
                inValid = !idle;
                inData = idle ? 32'h0 : ((i < 4) ? wordOf(key, i) : wordOf(pt, i - 4));
                accepted = inValid && (mMode == M_LOAD);
                tick();
                if (accepted) done = 1'b1;
                guard++;
            end
            if (!done) checkOutput("loadTimeout", 0, 1);
        end
        inValid = 1'b0;
        inData = '0;
    endtask

    task automatic waitCapture();
        int edges;
        edges = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            if (outValid) begin
                edges = k;
                break;
            end
        end
        checkOutput("captureEdge", edges, LAT);
    endtask

    task automatic drainBlock(input logic [127:0] ct, input int stall, input bit junk, input bit rnd);
        int n, guard;
        for (int s = 0; s < stall; s++) begin
            outReady = 1'b0;
            inValid = junk;
            inData = 32'hdeadbeef;
            checkOutput("stallValid", outValid, 1);
            checkOutput("stallData", outData, wordOf(ct, 0));
            checkOutput("stallInReady", inReady, 0);
            checkOutput("stallBusy", busy, 1);
            tick();
        end
        inValid = 1'b0;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 64) begin
            outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (outReady && outValid) begin
                checkOutput("drainWord", outData, wordOf(ct, n));
                n++;
            end
            tick();
            guard++;
        end
        outReady = 1'b0;
        checkOutput("drainCount", n, 4);
        checkOutput("doneOutValid", outValid, 0);
        checkOutput("doneInReady", inReady, 1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "InReady"}, inReady, 1);
        checkOutput({tag, "OutValid"}, outValid, 0);
        checkOutput({tag, "AesKey"}, aesKey, 0);
        checkOutput({tag, "AesState"}, aesState, 0);
        checkOutput({tag, "Busy"}, busy, 0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           gap;
        int           stall;
        bit           junk;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 1'b0};
        vecs[1] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 0, 10, 1'b1};
        vecs[2] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 1, 0, 1'b0};
        vecs[3] = '{B_KEY, B_PT, B_CT, 0, 3, 1'b1};

        rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b0;
        inValid1 = 1'b0; inData1 = '0; outReady1 = 1'b0; aesOut1 = ~FIPS_CT;
        tick();
        tick();
        rst = 1'b0;
        checkReset("reset");
        checkOutput("resetOutData", outData, 0);
        checkEn = 1'b1;

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].key, vecs[v].pt, vecs[v].gap);
            if (vecs[v].junk) begin
                inValid = 1'b1;
                inData = 32'hdeadbeef;
            end
            waitCapture();
            checkOutput("tblAesKey", aesKey, vecs[v].key);
            checkOutput("tblAesState", aesState, vecs[v].pt);
            drainBlock(vecs[v].ct, vecs[v].stall, vecs[v].junk, 1'b0);
        end

        applyStimulus(FIPS_KEY, FIPS_PT, 0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkReset("runReset");

        applyStimulus(B_KEY, B_PT, 0);
        waitCapture();
        outReady = 1'b1;
        tick();
        tick();
        outReady = 1'b0;
        checkOutput("midDrainData", outData, wordOf(B_CT, 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkReset("drainReset");

        applyStimulus(FIPS_KEY, FIPS_PT, 0);
        waitCapture();
        drainBlock(FIPS_CT, 0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [127:0] rk, rp;
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rk, rp, 2);
            if (r % 2 == 1) begin
                inValid = 1'b1;
                inData = 32'hdeadbeef;
            end
            waitCapture();
            drainBlock(coreModel(rk, rp), $urandom_range(0, 3), 1'(r % 2), 1'b1);
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("l1ResetReady", inReady1, 1);
        for (int i = 0; i < 8; i++) begin
            inValid1 = 1'b1;
            inData1 = (i < 4) ? wordOf(FIPS_KEY, i) : wordOf(FIPS_PT, i - 4);
            tick();
        end
        inValid1 = 1'b0;
        aesOut1 = FIPS_CT;
        checkOutput("l1PreValid", outValid1, 0);
        checkOutput("l1RunBusy", busy1, 1);
        checkOutput("l1RunInReady", inReady1, 0);
        checkOutput("l1AesKey", aesKey1, FIPS_KEY);
        checkOutput("l1AesState", aesState1, FIPS_PT);
        tick();
        aesOut1 = ~FIPS_CT;
        checkOutput("l1CaptureValid", outValid1, 1);
        outReady1 = 1'b1;
        for (int w = 0; w < 4; w++) begin
            checkOutput("l1DrainWord", outData1, wordOf(FIPS_CT, w));
            tick();
        end
        outReady1 = 1'b0;
        checkOutput("l1DoneValid", outValid1, 0);
        checkOutput("l1DoneInReady", inReady1, 1);
        checkOutput("l1DoneBusy", busy1, 0);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
